// File: rtl/operand_loader.sv
// operand_loader: synchronises switches/buttons, debounces buttons, and captures an A/B operand pair on a load press.
// Define OPERAND_LOADER_CIN_EN to add a debounced carry-in toggle button.
module operand_loader #(
  parameter int W         = 4,
  parameter int DB_CYCLES = 16000
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] sw_a,
  input  logic [W-1:0] sw_b,
  input  logic         btn_load,
  input  logic         btn_clear,
  input  logic         btn_cin,
  output logic [W-1:0] a_out,
  output logic [W-1:0] b_out,
  output logic         cin_out,
  output logic         valid,
  output logic         busy
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  // Button lanes: 0 = load, 1 = clear, 2 = carry toggle (when enabled)
`ifdef OPERAND_LOADER_CIN_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

  state_t          state, next_state;
  logic [W-1:0]    sw_a_meta, sw_a_sync, sw_b_meta, sw_b_sync;
  logic [NB-1:0]   btn_raw, btn_meta, btn_sync;
  logic [NB-1:0]   db, db_q, rise;
  logic [CW-1:0]   cnt [NB];
  logic            cin_rise;
  logic            do_clear, do_load, do_toggle;

`ifdef OPERAND_LOADER_CIN_EN
  assign btn_raw  = {btn_cin, btn_clear, btn_load};
  assign cin_rise = rise[2];
`else
  assign btn_raw  = {btn_clear, btn_load};
  assign cin_rise = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sw_a_meta <= '0;
      sw_a_sync <= '0;
      sw_b_meta <= '0;
      sw_b_sync <= '0;
      btn_meta  <= '0;
      btn_sync  <= '0;
    end else begin
      sw_a_meta <= sw_a;
      sw_a_sync <= sw_a_meta;
      sw_b_meta <= sw_b;
      sw_b_sync <= sw_b_meta;
      btn_meta  <= btn_raw;
      btn_sync  <= btn_meta;
    end
  end

  // A level change is accepted only after DB_CYCLES consecutive differing samples
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      db   <= '0;
      db_q <= '0;
      for (int i = 0; i < NB; i++) cnt[i] <= '0;
    end else begin
      db_q <= db;
      for (int i = 0; i < NB; i++) begin
        if (btn_sync[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DB_CYCLES - 1)) begin
          db[i]  <= ~db[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign rise = db & ~db_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    do_clear   = 1'b0;
    do_load    = 1'b0;
    do_toggle  = 1'b0;
    case (state)
      IDLE: begin
        if (rise[1]) begin
          do_clear   = 1'b1;
          next_state = PULSE;
        end else if (rise[0]) begin
          do_load    = 1'b1;
          next_state = PULSE;
        end else if (cin_rise) begin
          do_toggle  = 1'b1;
          next_state = PULSE;
        end
      end
      PULSE:   next_state = HOLD;
      HOLD:    if (db == '0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_out <= '0;
      b_out <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      valid <= (next_state == PULSE);
      busy  <= (next_state != IDLE);
      if (do_clear) begin
        a_out <= '0;
        b_out <= '0;
      end else if (do_load) begin
        a_out <= sw_a_sync;
        b_out <= sw_b_sync;
      end
    end
  end

`ifdef OPERAND_LOADER_CIN_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            cin_out <= 1'b0;
    else if (do_clear)  cin_out <= 1'b0;
    else if (do_toggle) cin_out <= ~cin_out;
  end
`else
  logic unused_cin;
  assign unused_cin = btn_cin ^ do_toggle;
  assign cin_out    = 1'b0;
`endif

endmodule

// File: tb/tb_operand_loader.sv
// Randomised self-checking bench for operand_loader with DB_CYCLES=4, compared against a history-based reference model.
// Honours OPERAND_LOADER_CIN_EN in the same way as the design.
module tb_operand_loader;

  localparam int W    = 4;
  localparam int N    = 4;
  localparam int HMAX = 8192;
`ifdef OPERAND_LOADER_CIN_EN
  localparam bit CIN_EN = 1'b1;
`else
  localparam bit CIN_EN = 1'b0;
`endif

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [W-1:0] sw_a = '0;
  logic [W-1:0] sw_b = '0;
  logic         btn_load = 1'b0;
  logic         btn_clear = 1'b0;
  logic         btn_cin = 1'b0;
  logic [W-1:0] a_out, b_out;
  logic         cin_out, valid, busy;

  always #5 CLK = ~CLK;

  operand_loader #(.W(W), .DB_CYCLES(N)) dut (
    .CLK(CLK), .RST(RST), .sw_a(sw_a), .sw_b(sw_b),
    .btn_load(btn_load), .btn_clear(btn_clear), .btn_cin(btn_cin),
    .a_out(a_out), .b_out(b_out), .cin_out(cin_out), .valid(valid), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int valid_seen = 0;
  int busy_seen = 0;
  int step_no = 0;
  int valid_step = 0;

  // Reference model: raw samples and accepted levels per clock edge since the last reset
  bit           rawh [3][HMAX];
  bit           dbh  [3][HMAX];
  logic [W-1:0] swh  [2][HMAX];
  int           e = 0;
  logic [W-1:0] m_a = '0, m_b = '0;
  bit           m_cin = 0, m_valid = 0, m_busy = 0;

  function automatic bit raw_at(input int k, input int idx);
    return (idx < 0) ? 1'b0 : rawh[k][idx];
  endfunction

  function automatic bit db_at(input int k, input int idx);
    return (idx < 0) ? 1'b0 : dbh[k][idx];
  endfunction

  function automatic logic [W-1:0] sw_at(input int k, input int idx);
    return (idx < 0) ? '0 : swh[k][idx];
  endfunction

  task automatic model_reset();
    e = 0;
    m_a = '0; m_b = '0; m_cin = 0; m_valid = 0; m_busy = 0;
  endtask

  task automatic model_edge();
    bit rise [3];
    bit cur, flip, any_db;
    rawh[0][e] = btn_load;
    rawh[1][e] = btn_clear;
    rawh[2][e] = btn_cin;
    swh[0][e]  = sw_a;
    swh[1][e]  = sw_b;
    // A level is accepted once the synchronised input has disagreed with it for N straight samples
    for (int k = 0; k < 3; k++) begin
      cur  = db_at(k, e - 1);
      flip = 1'b1;
      for (int j = 2; j <= N + 1; j++)
        if (raw_at(k, e - j) == cur) flip = 1'b0;
      dbh[k][e] = cur ^ flip;
      rise[k]   = db_at(k, e - 1) & ~db_at(k, e - 2);
    end
    any_db = db_at(0, e - 1) | db_at(1, e - 1) | (CIN_EN & db_at(2, e - 1));
    if (!m_busy) begin
      if (rise[1]) begin
        m_a = '0; m_b = '0; m_cin = 0; m_valid = 1; m_busy = 1;
      end else if (rise[0]) begin
        m_a = sw_at(0, e - 2); m_b = sw_at(1, e - 2); m_valid = 1; m_busy = 1;
      end else if (CIN_EN && rise[2]) begin
        m_cin = ~m_cin; m_valid = 1; m_busy = 1;
      end
    end else if (m_valid) begin
      m_valid = 0;
    end else if (!any_db) begin
      m_busy = 0;
    end
    e++;
  endtask

  always @(posedge CLK) begin
    if (!RST) model_edge();
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h expected %0h at t=%0t", tag, observed, expected, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLK);
      step_no++;
      checkOutput("a_out", a_out, m_a);
      checkOutput("b_out", b_out, m_b);
      checkOutput("cin_out", cin_out, m_cin);
      checkOutput("valid", valid, m_valid);
      checkOutput("busy", busy, m_busy);
      if (valid === 1'b1) begin
        valid_seen++;
        valid_step = step_no;
      end
      if (busy === 1'b1) busy_seen++;
    end
  endtask

  task automatic applyStimulus(input bit ld, input bit clr, input bit cn, input int n);
    btn_load  = ld;
    btn_clear = clr;
    btn_cin   = cn;
    step(n);
  endtask

  task automatic applyReset();
    RST = 1'b1;
    #1;
    model_reset();
    checkOutput("rst_a_out", a_out, 0);
    checkOutput("rst_b_out", b_out, 0);
    checkOutput("rst_cin_out", cin_out, 0);
    checkOutput("rst_valid", valid, 0);
    checkOutput("rst_busy", busy, 0);
    step(2);
    RST = 1'b0;
  endtask

  initial begin
    $display("[TB] operand_loader bench, DB_CYCLES=%0d, cin enabled=%0d", N, CIN_EN);
    applyReset();

    // Reset while a captured pair is held, then a fresh press must wait the full debounce
    sw_a = 4'h6; sw_b = 4'h7;
    applyStimulus(1, 0, 0, 12);
    checkOutput("pre_rst_a", a_out, 4'h6);
    applyReset();
    valid_seen = 0;
    step(6);
    checkOutput("rst_no_early_valid", valid_seen, 0);
    step(4);
    checkOutput("rst_fresh_valid", valid_seen, 1);
    applyStimulus(0, 0, 0, 15);
    checkOutput("rst_idle_busy", busy, 0);

    // Clean load
    sw_a = 4'hA; sw_b = 4'h5;
    valid_seen = 0; step_no = 0; valid_step = 0;
    applyStimulus(1, 0, 0, 20);
    checkOutput("clean_a", a_out, 4'hA);
    checkOutput("clean_b", b_out, 4'h5);
    checkOutput("clean_valid_cnt", valid_seen, 1);
    checkOutput("clean_valid_edge", valid_step, 7);
    busy_seen = 0;
    applyStimulus(0, 0, 0, 15);
    checkOutput("clean_busy_tail", busy_seen, 6);

    // Bounce rejection
    valid_seen = 0;
    for (int i = 0; i < 15; i++) applyStimulus((i % 2) == 0, 0, 0, 2);
    applyStimulus(0, 0, 0, 10);
    checkOutput("bounce_valid_cnt", valid_seen, 0);
    checkOutput("bounce_a", a_out, 4'hA);
    checkOutput("bounce_b", b_out, 4'h5);

    // Switch change while the load button is held
    valid_seen = 0;
    sw_a = 4'h3; sw_b = 4'($urandom_range(0, 15));
    applyStimulus(1, 0, 0, 8);
    sw_a = 4'h9;
    applyStimulus(1, 0, 0, 12);
    applyStimulus(0, 0, 0, 15);
    checkOutput("hold_a_first", a_out, 4'h3);
    checkOutput("hold_valid_cnt", valid_seen, 1);
    applyStimulus(1, 0, 0, 12);
    applyStimulus(0, 0, 0, 15);
    checkOutput("hold_a_second", a_out, 4'h9);
    checkOutput("hold_valid_cnt2", valid_seen, 2);

    // Load and clear on the same edge: clear wins
    valid_seen = 0;
    sw_a = 4'hF; sw_b = 4'($urandom_range(1, 15));
    applyStimulus(1, 1, 0, 12);
    applyStimulus(0, 0, 0, 15);
    checkOutput("simul_a", a_out, 0);
    checkOutput("simul_b", b_out, 0);
    checkOutput("simul_cin", cin_out, 0);
    checkOutput("simul_valid_cnt", valid_seen, 1);

    // Two carry presses
    valid_seen = 0;
    applyStimulus(0, 0, 1, 12);
    applyStimulus(0, 0, 0, 15);
    checkOutput("cin_first", cin_out, CIN_EN ? 1 : 0);
    checkOutput("cin_valid_cnt1", valid_seen, CIN_EN ? 1 : 0);
    applyStimulus(0, 0, 1, 12);
    applyStimulus(0, 0, 0, 15);
    checkOutput("cin_second", cin_out, 0);
    checkOutput("cin_valid_cnt2", valid_seen, CIN_EN ? 2 : 0);

    // Random button segments, some short enough to be rejected as bounce
    for (int s = 0; s < 220; s++) begin
      if ($urandom_range(0, 39) == 0) applyReset();
      sw_a = 4'($urandom_range(0, 15));
      sw_b = 4'($urandom_range(0, 15));
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(1, 12));
    end
    applyStimulus(0, 0, 0, 20);
    checkOutput("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
